// File: rtl/pwm_multi_if.sv
// pwm_multi_if: host duty-programming port shared by all PWM channels.
// The host (master) selects a channel, then writes or steps its shadow duty;
// the PWM block (slave) returns the selected shadow value combinationally.
interface pwm_multi_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  localparam int CSW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CSW-1:0]   ch_sel;
  logic             wr_en;
  logic [WIDTH-1:0] wr_duty;
  logic             duty_inc;
  logic             duty_dec;
  logic [WIDTH-1:0] duty_rd;

  modport master (
    output ch_sel, wr_en, wr_duty, duty_inc, duty_dec,
    input  duty_rd
  );

  modport slave (
    input  ch_sel, wr_en, wr_duty, duty_inc, duty_dec,
    output duty_rd
  );
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with one shared prescaler and
// period counter, per-channel shadow/active duty registers and a host port.
// Optional macro PWM_MULTI_INVERT_EN adds i_pol to invert (and idle-high)
// individual outputs.
//
// Counter direction FSM (only leaves DIR_UP when CENTER=1):
//   state    | meaning
//   DIR_UP   | counter rising 0..MAX (edge mode stays here and wraps)
//   DIR_DOWN | counter falling MAX-1..1, boundary when leaving 1
module pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int DIV_W    = 4,
  parameter bit CENTER   = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [DIV_W-1:0]    i_div,
`ifdef PWM_MULTI_INVERT_EN
  input  logic [CHANNELS-1:0] i_pol,
`endif
  pwm_multi_if.slave          host,
  output logic [CHANNELS-1:0] o_pwm_out,
  output logic                o_period_start
);

  localparam int               CSW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  dir_t                r_dir, w_dir_nxt;
  logic [DIV_W-1:0]    r_presc;
  logic [WIDTH-1:0]    r_cnt, w_cnt_nxt;
  logic                w_tick;
  logic                w_boundary;
  logic [WIDTH-1:0]    r_shadow [CHANNELS];
  logic [WIDTH-1:0]    r_active [CHANNELS];
  logic [CHANNELS-1:0] r_pwm;
  logic [CHANNELS-1:0] w_cmp;
  logic [CHANNELS-1:0] w_pol;
  logic                r_period_start;
  logic [CSW-1:0]      w_sel;
  logic                w_sel_ok;

`ifdef PWM_MULTI_INVERT_EN
  assign w_pol = i_pol;
`else
  assign w_pol = '0;
`endif

  assign w_sel    = host.ch_sel;
  assign w_sel_ok = ({{(32-CSW){1'b0}}, w_sel} < 32'(CHANNELS));

  // >= rather than == so that lowering div mid-count never waits for a wrap
  assign w_tick = i_en && (r_presc >= i_div);

  // Prescaler: free-runs while enabled, parked at 0 otherwise
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + DIV_W'(1);
    end
  end

  // Counter/direction state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en) begin
      r_cnt <= '0;
      r_dir <= DIR_UP;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  // Counter next-state and period boundary detection
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_dir_nxt  = r_dir;
    w_boundary = 1'b0;
    if (w_tick) begin
      if (!CENTER) begin
        w_cnt_nxt  = r_cnt + WIDTH'(1);
        w_boundary = (r_cnt == MAX);
      end else begin
        case (r_dir)
          DIR_UP: begin
            if (r_cnt == MAX) begin
              w_dir_nxt = DIR_DOWN;
              w_cnt_nxt = r_cnt - WIDTH'(1);
            end else begin
              w_cnt_nxt = r_cnt + WIDTH'(1);
            end
          end
          DIR_DOWN: begin
            if (r_cnt == WIDTH'(1)) begin
              w_dir_nxt  = DIR_UP;
              w_cnt_nxt  = '0;
              w_boundary = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt - WIDTH'(1);
            end
          end
          default: begin
            w_dir_nxt = DIR_UP;
            w_cnt_nxt = '0;
          end
        endcase
      end
    end
  end

  // Per-channel compare against the pre-increment counter value
  always_comb begin
    w_cmp = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cmp[i] = (r_active[i] > r_cnt);
    end
  end

  // Output register and boundary pulse; outputs idle at their polarity
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en) begin
      r_pwm          <= w_pol;
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_boundary;
      if (w_tick) begin
        r_pwm <= w_cmp ^ w_pol;
      end
    end
  end

  // Shadow updates from the host and shadow-to-active transfer
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= HALF;
        r_active[i] <= HALF;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        // Active reads the old shadow, so a same-cycle host write waits a period
        if (!i_en || w_boundary) begin
          r_active[i] <= r_shadow[i];
        end
        if (w_sel_ok && (w_sel == CSW'(i))) begin
          if (host.wr_en) begin
            r_shadow[i] <= host.wr_duty;
          end else if (host.duty_inc && !host.duty_dec) begin
            if (r_shadow[i] != MAX) r_shadow[i] <= r_shadow[i] + WIDTH'(1);
          end else if (host.duty_dec && !host.duty_inc) begin
            if (r_shadow[i] != '0) r_shadow[i] <= r_shadow[i] - WIDTH'(1);
          end
        end
      end
    end
  end

  assign host.duty_rd   = w_sel_ok ? r_shadow[w_sel] : '0;
  assign o_pwm_out      = r_pwm;
  assign o_period_start = r_period_start;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: runs an edge-aligned and a centre-aligned pwm_multi side by
// side from the same stimulus and compares both against a period-position
// reference model, plus direct duty/period measurements.
module tb_pwm_multi;
  localparam int CH = 3;
  localparam int W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, en;
  logic [3:0]    div;
  logic [1:0]    ch_sel;
  logic          wr_en, inc, dec;
  logic [W-1:0]  wr_duty;
  logic [CH-1:0] pwm_e, pwm_c;
  logic          ps_e, ps_c;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_multi_if #(.CHANNELS(CH), .WIDTH(W)) if_e ();
  pwm_multi_if #(.CHANNELS(CH), .WIDTH(W)) if_c ();

  assign if_e.ch_sel = ch_sel;  assign if_c.ch_sel = ch_sel;
  assign if_e.wr_en = wr_en;    assign if_c.wr_en = wr_en;
  assign if_e.wr_duty = wr_duty; assign if_c.wr_duty = wr_duty;
  assign if_e.duty_inc = inc;   assign if_c.duty_inc = inc;
  assign if_e.duty_dec = dec;   assign if_c.duty_dec = dec;

  pwm_multi #(.CHANNELS(CH), .WIDTH(W), .DIV_W(4), .CENTER(1'b0)) u_edge (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div(div),
`ifdef PWM_MULTI_INVERT_EN
    .i_pol(3'b000),
`endif
    .host(if_e), .o_pwm_out(pwm_e), .o_period_start(ps_e)
  );

  pwm_multi #(.CHANNELS(CH), .WIDTH(W), .DIV_W(4), .CENTER(1'b1)) u_ctr (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div(div),
`ifdef PWM_MULTI_INVERT_EN
    .i_pol(3'b000),
`endif
    .host(if_c), .o_pwm_out(pwm_c), .o_period_start(ps_c)
  );

  // Reference model: position within the period (0..per-1) instead of a
  // counter/direction pair; counter value derived arithmetically from it.
  int            m_presc [2];
  int            m_pos   [2];
  logic [W-1:0]  m_sh    [2][CH];
  logic [W-1:0]  m_act   [2][CH];
  logic [CH-1:0] m_pwm   [2];
  logic          m_ps    [2];
  int            mc, per;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      per = (k == 0) ? 256 : 510;
      if (!rst_n) begin
        m_presc[k] = 0; m_pos[k] = 0; m_pwm[k] = '0; m_ps[k] = 1'b0;
        for (int i = 0; i < CH; i++) begin m_sh[k][i] = 8'd128; m_act[k][i] = 8'd128; end
      end else begin
        if (!en) begin
          m_presc[k] = 0; m_pos[k] = 0; m_pwm[k] = '0; m_ps[k] = 1'b0;
          for (int i = 0; i < CH; i++) m_act[k][i] = m_sh[k][i];
        end else begin
          m_ps[k] = 1'b0;
          if (m_presc[k] >= int'(div)) begin
            m_presc[k] = 0;
            mc = (k == 0 || m_pos[k] <= 255) ? m_pos[k] : per - m_pos[k];
            for (int i = 0; i < CH; i++) m_pwm[k][i] = (int'(m_act[k][i]) > mc);
            if (m_pos[k] == per - 1) begin
              m_pos[k] = 0;
              m_ps[k]  = 1'b1;
              for (int i = 0; i < CH; i++) m_act[k][i] = m_sh[k][i];
            end else begin
              m_pos[k]++;
            end
          end else begin
            m_presc[k]++;
          end
        end
        if (ch_sel < CH) begin
          if (wr_en) m_sh[k][ch_sel] = wr_duty;
          else if (inc && !dec) begin
            if (m_sh[k][ch_sel] != 8'hFF) m_sh[k][ch_sel] = m_sh[k][ch_sel] + 8'd1;
          end else if (dec && !inc) begin
            if (m_sh[k][ch_sel] != 8'h00) m_sh[k][ch_sel] = m_sh[k][ch_sel] - 8'd1;
          end
        end
      end
    end
  end

  function automatic logic [23:0] exp_vec();
    logic [7:0] re, rc;
    re = (ch_sel < CH) ? m_sh[0][ch_sel] : 8'h00;
    rc = (ch_sel < CH) ? m_sh[1][ch_sel] : 8'h00;
    return {m_pwm[0], m_ps[0], re, m_pwm[1], m_ps[1], rc};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {pwm_e, ps_e, if_e.duty_rd, pwm_c, ps_c, if_c.duty_rd};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; div = 4'd0;
    ch_sel = 2'd0; wr_en = 1'b0; wr_duty = 8'd0; inc = 1'b0; dec = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({pwm_e, ps_e, pwm_c, ps_c} !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=0", {pwm_e, ps_e, pwm_c, ps_c});
    end
    n_tests++;
    if (if_e.duty_rd !== 8'd128 || if_c.duty_rd !== 8'd128) begin
      n_fail++; $display("FAIL reset_duty got=%0d/%0d exp=128", if_e.duty_rd, if_c.duty_rd);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_edge_basic();
    int state = 0, hi = 0, len = 0, cyc = 0, start = 0;
    en = 1'b1; div = 4'd0;
    repeat (700) begin
      @(negedge clk); cyc++;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL model_edge_basic t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      if (ps_e && state == 1) begin len = cyc - start; state = 2; end
      if (ps_e && state == 0) begin start = cyc; state = 1; end
      if (state == 1 && pwm_e[0]) hi++;
    end
    n_tests++;
    if (state != 2 || len != 256 || hi != 128) begin
      n_fail++; $display("FAIL edge_50pct len=%0d hi=%0d exp 256/128", len, hi);
    end
  endtask

  task automatic test_write_mid();
    int state = 0, hi = 0, cyc = 0;
    repeat (100) @(negedge clk);
    ch_sel = 2'd1; wr_duty = 8'd64; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    n_tests++;
    if (if_e.duty_rd !== 8'd64) begin
      n_fail++; $display("FAIL write_readback got=%0d exp=64", if_e.duty_rd);
    end
    while (state != 2 && cyc < 800) begin
      @(negedge clk); cyc++;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL model_write_mid t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      if (ps_e && state == 1) state = 2;
      if (ps_e && state == 0) state = 1;
      if (state == 1 && pwm_e[1]) hi++;
    end
    n_tests++;
    if (state != 2 || hi != 64) begin
      n_fail++; $display("FAIL ch1_duty64 hi=%0d exp=64 (state %0d)", hi, state);
    end
  endtask

  typedef struct {int sel; bit wr; int d; bit up; bit dn; int rd;} op_t;

  task automatic test_saturate();
    op_t ops[$];
    ops.push_back('{2, 1'b1, 255, 1'b0, 1'b0, 255});
    ops.push_back('{2, 1'b0, 0,   1'b1, 1'b0, 255});
    ops.push_back('{2, 1'b0, 0,   1'b1, 1'b0, 255});
    ops.push_back('{2, 1'b0, 0,   1'b1, 1'b0, 255});
    ops.push_back('{2, 1'b1, 0,   1'b0, 1'b0, 0});
    ops.push_back('{2, 1'b0, 0,   1'b0, 1'b1, 0});
    ops.push_back('{2, 1'b1, 77,  1'b0, 1'b0, 77});
    ops.push_back('{2, 1'b0, 0,   1'b1, 1'b1, 77});
    ops.push_back('{2, 1'b1, 78,  1'b1, 1'b0, 78});
    ops.push_back('{2, 1'b0, 0,   1'b0, 1'b1, 77});
    ops.push_back('{3, 1'b1, 9,   1'b0, 1'b0, 0});
    ops.push_back('{0, 1'b0, 0,   1'b0, 1'b0, 128});
    ops.push_back('{1, 1'b0, 0,   1'b0, 1'b0, 64});
    ops.push_back('{2, 1'b0, 0,   1'b0, 1'b0, 77});
    foreach (ops[j]) begin
      ch_sel = 2'(ops[j].sel); wr_en = ops[j].wr; wr_duty = 8'(ops[j].d);
      inc = ops[j].up; dec = ops[j].dn;
      @(negedge clk);
      wr_en = 1'b0; inc = 1'b0; dec = 1'b0;
      n_tests++;
      if (if_e.duty_rd !== 8'(ops[j].rd) || if_c.duty_rd !== 8'(ops[j].rd)) begin
        n_fail++; $display("FAIL host_op%0d got=%0d/%0d exp=%0d", j, if_e.duty_rd, if_c.duty_rd, ops[j].rd);
      end
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL model_host_op%0d got=%h exp=%h", j, dut_vec(), exp_vec());
      end
    end
    ch_sel = 2'd0;
  endtask

  task automatic test_div();
    int state = 0, len = 0, cyc = 0, start = 0, waited = 0;
    div = 4'd3;
    while (state != 2 && cyc < 2600) begin
      @(negedge clk); cyc++;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL model_div3 t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      if (ps_e && state == 1) begin len = cyc - start; state = 2; end
      if (ps_e && state == 0) begin start = cyc; state = 1; end
    end
    n_tests++;
    if (state != 2 || len != 1024) begin
      n_fail++; $display("FAIL div3_period len=%0d exp=1024", len);
    end
    while (m_presc[0] != 2 && waited < 8) begin @(negedge clk); waited++; end
    n_tests++;
    if (m_presc[0] != 2) begin
      n_fail++; $display("FAIL div_wait_presc2 got=%0d exp=2", m_presc[0]);
    end
    div = 4'd1;
    repeat (300) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL model_div_change t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
    end
    div = 4'd0;
  endtask

  task automatic test_center();
    int state = 0, hi = 0, len = 0, cyc = 0, start = 0;
    ch_sel = 2'd0; wr_duty = 8'd100; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    while (state != 3 && cyc < 2200) begin
      @(negedge clk); cyc++;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL model_center t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      if (ps_c && state == 2) begin len = cyc - start; state = 3; end
      if (ps_c && state == 1) begin start = cyc; state = 2; end
      if (ps_c && state == 0) state = 1;
      if (state == 2 && pwm_c[0]) hi++;
    end
    n_tests++;
    if (state != 3 || len != 510 || hi != 199) begin
      n_fail++; $display("FAIL center_duty100 len=%0d hi=%0d exp 510/199", len, hi);
    end
  endtask

  task automatic test_enable();
    int k = 0, hi = 0, got_ps = 0;
    repeat (50) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (pwm_e !== 3'b000 || pwm_c !== 3'b000 || ps_e !== 1'b0 || ps_c !== 1'b0) begin
      n_fail++; $display("FAIL en_low_outputs got=%b %b exp=000 000", pwm_e, pwm_c);
    end
    ch_sel = 2'd0; wr_duty = 8'd32; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    while (!got_ps && k < 300) begin
      @(negedge clk); k++;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL model_reenable t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      if (ps_e) got_ps = 1;
      else if (pwm_e[0]) hi++;
    end
    n_tests++;
    if (!got_ps || k != 256 || hi != 32) begin
      n_fail++; $display("FAIL reenable_first_period k=%0d hi=%0d exp 256/32", k, hi);
    end
  endtask

  task automatic test_reset_mid();
    repeat (100) @(negedge clk);
    rst_n = 1'b0; ch_sel = 2'd0;
    @(negedge clk);
    n_tests++;
    if (pwm_e !== 3'b000 || pwm_c !== 3'b000 || if_e.duty_rd !== 8'd128) begin
      n_fail++; $display("FAIL reset_mid got=%b %b rd=%0d exp=000 000 rd=128", pwm_e, pwm_c, if_e.duty_rd);
    end
    rst_n = 1'b1;
    repeat (300) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL model_after_reset t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    repeat (4000) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL model_random t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      rst_n   = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 199) == 0) en = ~en;
      if ($urandom_range(0, 299) == 0) div = 4'($urandom_range(0, 2));
      ch_sel  = 2'($urandom_range(0, 3));
      wr_en   = ($urandom_range(0, 19) == 0);
      wr_duty = 8'($urandom_range(0, 255));
      inc     = ($urandom_range(0, 7) == 0);
      dec     = ($urandom_range(0, 7) == 0);
    end
    wr_en = 1'b0; inc = 1'b0; dec = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_write_mid();
    test_saturate();
    test_div();
    test_center();
    test_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
